// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control FSM: Moore decode of datapath selects and strobes,
// with fetch/branch write-enables qualified by the memory handshake and zero flag.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic [1:0] alu_operation_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic       adr_src_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e state_q;
    state_e state_d;

    logic mem_read_s;
    logic mem_write_s;
    logic ir_write_s;
    logic pc_write_s;
    logic reg_write_s;
    logic illegal_s;

    // State register; reset returns to FETCH from anywhere, including TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R_TYPE:         state_d = S_EXEC_R;
                    OP_I_TYPE:         state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR:   state_d = (opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Output decode from state; only FETCH/BRANCH write-enables look at inputs.
    always_comb begin
        alu_operation_o = 2'b00;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        result_src_o    = 2'b00;
        adr_src_o       = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        illegal_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                mem_read_s   = 1'b1;
                ir_write_s   = mem_ready_i;
                pc_write_s   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
            end
            S_MEM_ADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_MEM_READ: begin
                adr_src_o  = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEM_WB: begin
                result_src_o = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src_o   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o     = 2'b10;
                alu_operation_o = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a_o     = 2'b10;
                alu_src_b_o     = 2'b01;
                alu_operation_o = 2'b10;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 2'b10;
                alu_operation_o = 2'b01;
                pc_write_s      = zero_i;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // During reset the state already reads FETCH; strobes are also held low.
    assign mem_read_o  = mem_read_s  & rst_n;
    assign mem_write_o = mem_write_s & rst_n;
    assign ir_write_o  = ir_write_s  & rst_n;
    assign pc_write_o  = pc_write_s  & rst_n;
    assign reg_write_o = reg_write_s & rst_n;
    assign illegal_o   = illegal_s   & rst_n;
    assign state_o     = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: directed per-cycle vectors push expected
// state/outputs; a negedge monitor pops and compares.
module tb_main_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_operation, alu_src_a, alu_src_b, result_src;
    logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [3:0] state;

    main_control_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_i        (opcode),
        .zero_i          (zero),
        .mem_ready_i     (mem_ready),
        .alu_operation_o (alu_operation),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .result_src_o    (result_src),
        .adr_src_o       (adr_src),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .reg_write_o     (reg_write),
        .illegal_o       (illegal),
        .state_o         (state)
    );

    typedef struct packed {
        logic [15:0] step;
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   step_no = 0;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] BAD  = 7'b1111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs, packed {op,a,b,rs,adr,mrd,mwr,irw,pcw,rgw,ill}, taken from the state table.
    function automatic logic [14:0] exp_outs(input int st, input bit mr, input bit z, input bit rst);
        logic [1:0] op, a, b, rs;
        logic adr, mrd, mwr, irw, pcw, rgw, ill;
        op = 2'b00; a = 2'b00; b = 2'b00; rs = 2'b00;
        adr = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; pcw = 1'b0; rgw = 1'b0; ill = 1'b0;
        case (st)
            0:  begin b = 2'b10; rs = 2'b10; mrd = 1'b1; irw = mr; pcw = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin adr = 1'b1; mrd = 1'b1; end
            4:  begin rs = 2'b01; rgw = 1'b1; end
            5:  begin adr = 1'b1; mwr = 1'b1; end
            6:  begin a = 2'b10; op = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            8:  begin rgw = 1'b1; end
            9:  begin a = 2'b10; op = 2'b01; pcw = z; end
            10: begin ill = 1'b1; end
            default: begin ill = 1'b1; end
        endcase
        if (rst) begin
            mrd = 1'b0; mwr = 1'b0; irw = 1'b0; pcw = 1'b0; rgw = 1'b0; ill = 1'b0;
        end
        return {op, a, b, rs, adr, mrd, mwr, irw, pcw, rgw, ill};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic step(input bit rst, input logic [6:0] op, input bit mr, input bit z, input int exp_st);
        exp_t e;
        rst_n     = !rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        e.step = step_no[15:0];
        e.st   = exp_st[3:0];
        e.outs = exp_outs(exp_st, mr, z, rst);
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [14:0] got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {alu_operation, alu_src_a, alu_src_b, result_src, adr_src,
                   mem_read, mem_write, ir_write, pc_write, reg_write, illegal};
            tests_run++;
            if (state !== e.st) begin
                tests_failed++;
                $display("FAIL state step=%0d got %0d expected %0d", e.step, state, e.st);
            end
            tests_run++;
            if (got !== e.outs) begin
                tests_failed++;
                $display("FAIL outputs step=%0d state=%0d got %b expected %b", e.step, e.st, got, e.outs);
            end
            tests_run++;
            if ((mem_read && mem_write) || (reg_write && mem_write)) begin
                tests_failed++;
                $display("FAIL strobe_exclusive step=%0d got mrd=%b mwr=%b rgw=%b expected no overlap",
                         e.step, mem_read, mem_write, reg_write);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        // Reset state: FETCH selects, strobes low even with mem_ready high.
        step(1'b1, RTY, 1'b1, 1'b0, 0);
        step(1'b1, RTY, 1'b1, 1'b0, 0);

        // R-type: 0,1,6,8
        step(1'b0, RTY, 1'b1, 1'b0, 0);
        step(1'b0, RTY, 1'b1, 1'b0, 1);
        step(1'b0, RTY, 1'b1, 1'b0, 6);
        step(1'b0, RTY, 1'b1, 1'b0, 8);
        // I-type: 0,1,7,8
        step(1'b0, ITY, 1'b1, 1'b0, 0);
        step(1'b0, ITY, 1'b1, 1'b0, 1);
        step(1'b0, ITY, 1'b1, 1'b0, 7);
        step(1'b0, ITY, 1'b1, 1'b0, 8);
        // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
        step(1'b0, LW, 1'b1, 1'b0, 0);
        step(1'b0, LW, 1'b1, 1'b0, 1);
        step(1'b0, LW, 1'b1, 1'b0, 2);
        step(1'b0, LW, 1'b0, 1'b0, 3);
        step(1'b0, LW, 1'b0, 1'b0, 3);
        step(1'b0, LW, 1'b1, 1'b0, 3);
        step(1'b0, LW, 1'b1, 1'b0, 4);
        // sw: 0,1,2,5
        step(1'b0, SW, 1'b1, 1'b0, 0);
        step(1'b0, SW, 1'b1, 1'b0, 1);
        step(1'b0, SW, 1'b1, 1'b0, 2);
        step(1'b0, SW, 1'b1, 1'b0, 5);
        // beq taken then not taken
        step(1'b0, BEQ, 1'b1, 1'b1, 0);
        step(1'b0, BEQ, 1'b1, 1'b1, 1);
        step(1'b0, BEQ, 1'b1, 1'b1, 9);
        step(1'b0, BEQ, 1'b1, 1'b0, 0);
        step(1'b0, BEQ, 1'b1, 1'b0, 1);
        step(1'b0, BEQ, 1'b1, 1'b0, 9);
        // FETCH stall for three cycles, then I-type completes
        step(1'b0, ITY, 1'b0, 1'b0, 0);
        step(1'b0, ITY, 1'b0, 1'b0, 0);
        step(1'b0, ITY, 1'b0, 1'b0, 0);
        step(1'b0, ITY, 1'b1, 1'b0, 0);
        step(1'b0, ITY, 1'b1, 1'b0, 1);
        step(1'b0, ITY, 1'b1, 1'b0, 7);
        step(1'b0, ITY, 1'b1, 1'b0, 8);
        // sw, reset asserted mid-handshake in MEM_WRITE
        step(1'b0, SW, 1'b1, 1'b0, 0);
        step(1'b0, SW, 1'b1, 1'b0, 1);
        step(1'b0, SW, 1'b1, 1'b0, 2);
        step(1'b0, SW, 1'b0, 1'b0, 5);
        step(1'b0, SW, 1'b0, 1'b0, 5);
        step(1'b1, SW, 1'b0, 1'b0, 0);
        step(1'b0, RTY, 1'b1, 1'b0, 0);
        step(1'b0, RTY, 1'b1, 1'b0, 1);
        step(1'b0, RTY, 1'b1, 1'b0, 6);
        step(1'b0, RTY, 1'b1, 1'b0, 8);
        // Illegal opcode: DECODE then TRAP, sticky regardless of inputs
        step(1'b0, BAD, 1'b1, 1'b0, 0);
        step(1'b0, BAD, 1'b1, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i % 2 == 0) ? LW : BAD, i[0], i[1], 10);
        end
        step(1'b1, BAD, 1'b1, 1'b0, 0);
        step(1'b0, LW, 1'b1, 1'b0, 0);
        step(1'b0, LW, 1'b1, 1'b0, 1);
        step(1'b0, LW, 1'b1, 1'b0, 2);
        step(1'b0, LW, 1'b1, 1'b0, 3);
        step(1'b0, LW, 1'b1, 1'b0, 4);
        step(1'b0, LW, 1'b1, 1'b0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 5) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have no parameters; all state encodings and opcode values are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  7  instruction opcode from the instruction register; stable outside FETCH.
REQ-005 zero  input  1  ALU zero flag for the current cycle.
REQ-006 mem_ready  input  1  memory handshake; high = access completes this cycle.
REQ-007 alu_operation  output  2  00 add, 01 subtract, 10 decode from func3/func7; drives alu_control.
REQ-008 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1.
REQ-009 alu_src_b  output  2  00 rs2, 01 immediate, 10 constant 4.
REQ-010 result_src  output  2  00 ALU-out register, 01 memory data, 10 live ALU result.
REQ-011 adr_src  output  1  0 PC, 1 result bus as memory address.
REQ-012 mem_read / mem_write / ir_write / pc_write / reg_write  output  1 each  strobes.
REQ-013 illegal  output  1  high while in TRAP.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 States and encodings SHALL be: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, TRAP 10; codes 11-15 SHALL transition to TRAP.
REQ-016 Outputs SHALL be decoded from state only (Moore), except pc_write in FETCH and BRANCH and ir_write in FETCH; any output not listed for a state is 0.
REQ-017 FETCH: adr_src 0, mem_read 1, a 00, b 10, op 00, result_src 10; ir_write = pc_write = mem_ready; stay while mem_ready 0, else DECODE.
REQ-018 DECODE: a 01, b 01, op 00 (branch target); next by opcode: 0000011 or 0100011 -> MEM_ADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, any other -> TRAP.
REQ-019 MEM_ADR: a 10, b 01, op 00; next MEM_READ if opcode 0000011, else MEM_WRITE.
REQ-020 MEM_READ: result_src 00, adr_src 1, mem_read 1; stay while mem_ready 0, else MEM_WB.
REQ-021 MEM_WB: result_src 01, reg_write 1; next FETCH.
REQ-022 MEM_WRITE: result_src 00, adr_src 1, mem_write 1; stay while mem_ready 0, else FETCH.
REQ-023 EXEC_R: a 10, b 00, op 10; EXEC_I: a 10, b 01, op 10; both next ALU_WB.
REQ-024 ALU_WB: result_src 00, reg_write 1; next FETCH.
REQ-025 BRANCH: a 10, b 00, op 01, result_src 00, pc_write = zero; next FETCH regardless of zero.
REQ-026 TRAP: all strobes 0, illegal 1; SHALL stay in TRAP until reset; mem_ready and opcode ignored.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle; reg_write and mem_write SHALL never be high in the same cycle.
REQ-028 Instruction latency, with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, beq 3; each cycle of mem_ready low adds one cycle.

Reset
REQ-029 rst_n low SHALL force state to FETCH immediately, asynchronously, in any state including TRAP or mid-handshake.
REQ-030 While rst_n is low, all strobes and illegal SHALL be 0; alu and mux selects SHALL take FETCH values.
REQ-031 The first rising edge after rst_n rises SHALL evaluate FETCH normally; a pending memory access is abandoned.

Verification
REQ-032 opcode 0110011, mem_ready 1 -> states 0,1,6,8,0; op 10 in state 6; reg_write 1 only in state 8.
REQ-033 opcode 0000011, mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; mem_read and adr_src 1 throughout state 3.
REQ-034 opcode 1100011 with zero 1 -> pc_write 1 in BRANCH, op 01; repeated with zero 0 -> pc_write 0; both return to FETCH.
REQ-035 opcode 1111111 -> DECODE then TRAP; illegal 1, all strobes 0 for 10+ cycles; rst_n pulse -> FETCH, illegal 0.
REQ-036 opcode 0100011, rst_n asserted while in MEM_WRITE with mem_ready 0 -> state 0 and mem_write 0 before the next clock edge.
REQ-037 mem_ready 0 held in FETCH for 3 cycles -> state stays 0, ir_write and pc_write 0 until mem_ready 1.
